mdu_iter: RTL and testbench

- Parametrised multiply/divide unit for the EX stage; successor to the fixed 32-bit MDU.
- Runs signed/unsigned mult, div and multiply-accumulate (madd/msub) with configurable latency.
- Owns HI/LO, services mthi/mtlo writes and mfhi/mflo reads, and raises busy so the hazard unit can stall.
- Has a cancel input so an in-flight operation can be squashed on exception/flush.

---
 rtl/mdu_iter.sv | 156 +++++++++++++++
 tb/tb_mdu_iter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative-latency multiply/divide unit: owns HI/LO, runs mult/div/madd/msub with
// fixed configurable latency, services mthi/mtlo and supports in-flight cancel.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             rd_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_0  = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_1  = CW'(1);

  function automatic logic is_arith(input logic [3:0] o);
    return (o >= OP_MULT) && (o <= OP_MSUBU);
  endfunction

  logic [CW-1:0]    count_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic             idle_s;
  logic             accept_s;
  logic             wr_hi_s;
  logic             wr_lo_s;
  logic [CW-1:0]    lat_s;
  logic             signed_s;
  logic             neg_a_s;
  logic             neg_b_s;
  logic [W2-1:0]    ext_a_s;
  logic [W2-1:0]    ext_b_s;
  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    acc_s;
  logic [W2-1:0]    res_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] div_b_s;
  logic [WIDTH-1:0] uq_s;
  logic [WIDTH-1:0] ur_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  assign idle_s   = (count_r == CNT_0);
  assign accept_s = start & ~cancel & idle_s & is_arith(op);
  assign wr_hi_s  = start & ~cancel & idle_s & (op == OP_MTHI);
  assign wr_lo_s  = start & ~cancel & idle_s & (op == OP_MTLO);
  assign lat_s    = ((op == OP_DIV) || (op == OP_DIVU)) ? CW'(DIV_LAT) : CW'(MUL_LAT);
  assign busy     = (start & is_arith(op)) | ~idle_s;
  assign rdata    = rd_sel ? hi : lo;

  // Result datapath from latched operands and committed HI/LO (HI/LO are frozen while busy).
  always_comb begin
    signed_s = 1'b0;
    case (op_r)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: signed_s = 1'b1;
      default:                           signed_s = 1'b0;
    endcase
    neg_a_s = signed_s & a_r[WIDTH-1];
    neg_b_s = signed_s & b_r[WIDTH-1];
    // Sign/zero extension to 2*WIDTH makes one truncated product serve both signednesses.
    ext_a_s = {{WIDTH{neg_a_s}}, a_r};
    ext_b_s = {{WIDTH{neg_b_s}}, b_r};
    prod_s  = ext_a_s * ext_b_s;
    acc_s   = {hi, lo};
    mag_a_s = neg_a_s ? -a_r : a_r;
    mag_b_s = neg_b_s ? -b_r : b_r;
    div_b_s = (b_r == ZERO_W) ? ONE_W : mag_b_s;
    uq_s    = mag_a_s / div_b_s;
    ur_s    = mag_a_s % div_b_s;
    // Most-negative / -1 falls out as quotient = a, remainder = 0 through the magnitude path.
    quo_s   = (neg_a_s ^ neg_b_s) ? -uq_s : uq_s;
    rem_s   = neg_a_s ? -ur_s : ur_s;
    res_s   = acc_s;
    case (op_r)
      OP_MULT, OP_MULTU: res_s = prod_s;
      OP_MADD, OP_MADDU: res_s = acc_s + prod_s;
      OP_MSUB, OP_MSUBU: res_s = acc_s - prod_s;
      OP_DIV, OP_DIVU: begin
        if (b_r == ZERO_W) begin
          res_s = {a_r, ONES_W};
        end else begin
          res_s = {rem_s, quo_s};
        end
      end
      default: res_s = acc_s;
    endcase
  end

  // Latency counter, operand latches, HI/LO commit and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= CNT_0;
      op_r    <= 4'd0;
      a_r     <= ZERO_W;
      b_r     <= ZERO_W;
      hi      <= ZERO_W;
      lo      <= ZERO_W;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        count_r <= CNT_0;
      end else if (count_r == CNT_1) begin
        count_r <= CNT_0;
        hi      <= res_s[W2-1:WIDTH];
        lo      <= res_s[WIDTH-1:0];
        done    <= 1'b1;
      end else if (!idle_s) begin
        count_r <= count_r - CNT_1;
      end else if (accept_s) begin
        count_r <= lat_s;
        op_r    <= op;
        a_r     <= a;
        b_r     <= b;
      end else if (wr_hi_s) begin
        hi <= a;
      end else if (wr_lo_s) begin
        lo <= a;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized scoreboard bench for mdu_iter: a plain-arithmetic HI/LO model predicts each
// commit, and a done-driven monitor compares committed HI/LO against the queued prediction.
module tb_mdu_iter;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             rd_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_iter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .rd_sel(rd_sel), .busy(busy), .done(done),
    .rdata(rdata), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: {hi,lo} after an arithmetic op, from 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] acc);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = x;
    longint unsigned uy = y;
    logic [63:0]     ps = sx * sy;
    logic [63:0]     pu = ux * uy;
    logic [63:0]     q;
    logic [63:0]     r;
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd5: return acc + ps;
      4'd6: return acc + pu;
      4'd7: return acc - ps;
      4'd8: return acc - pu;
      4'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = ux / uy;
        r = ux % uy;
        return {r[31:0], q[31:0]};
      end
      default: return acc;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'd0);
      else check("commit_hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  // cancel_at: 0 = run to completion, k = assert cancel in the k-th cycle after accept.
  // intrude: 0 none, 1 second arith start while busy, 2 mthi while busy.
  task automatic arith(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int cancel_at, input int intrude);
    int          lat;
    logic [63:0] prev;
    logic [63:0] expv;
    logic        was_cancel;
    lat  = (o == 4'd3 || o == 4'd4) ? DIV_LAT : MUL_LAT;
    prev = {m_hi, m_lo};
    expv = model(o, x, y, prev);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check("busy_start", 64'(busy), 64'd1);
    if (cancel_at == 0) begin
      exp_q.push_back(expv);
      {m_hi, m_lo} = expv;
    end
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'd0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      if (intrude == 1 && cyc == 2) begin
        start = 1'b1; op = 4'($urandom_range(1, 8)); a = $urandom; b = $urandom;
      end
      if (intrude == 2 && cyc == 2) begin
        start = 1'b1; op = 4'd9; a = $urandom;
      end
      if (cyc == cancel_at) cancel = 1'b1;
      #1;
      check("busy_inflight", 64'(busy), 64'd1);
      check("hilo_hold", {hi, lo}, prev);
      @(posedge clk);
      #1;
      start = 1'b0; op = 4'd0;
      was_cancel = cancel;
      cancel = 1'b0;
      #1;
      if (was_cancel) begin
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_hilo", {hi, lo}, prev);
        return;
      end
      check("done_timing", 64'(done), 64'(cyc == lat));
    end
    check("busy_after", 64'(busy), 64'd0);
    rd_sel = 1'b0;
    #1;
    check("rdata_lo", 64'(rdata), 64'(expv[31:0]));
    rd_sel = 1'b1;
    #1;
    check("rdata_hi", 64'(rdata), 64'(expv[63:32]));
    rd_sel = 1'b0;
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic mtx(input bit to_hi, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = to_hi ? 4'd9 : 4'd10; a = x;
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'd0;
    if (to_hi) m_hi = x;
    else m_lo = x;
    check(to_hi ? "mthi" : "mtlo", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic reset_mid_div();
    @(negedge clk);
    start = 1'b1; op = 4'd3; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("reset_mid_hilo", {hi, lo}, 64'd0);
    check("reset_mid_busy", 64'(busy), 64'd0);
    repeat (DIV_LAT + 2) @(posedge clk);
    #1;
    check("reset_mid_nodone", 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          sel;
    logic [3:0]  ro;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'd0;
    a = 32'd0; b = 32'd0; rd_sel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    start = 1'b1; op = 4'd1;
    #1;
    check("reset_busy_start", 64'(busy), 64'd1);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    reset = 1'b0;

    arith(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    arith(4'd4, 32'd7, 32'd2, 0, 0);
    check("plan_divu", {hi, lo}, 64'h0000_0001_0000_0003);
    arith(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("plan_div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    arith(4'd3, 32'd5, 32'd0, 0, 0);
    check("plan_div_zero", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    arith(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("plan_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    mtx(1'b1, 32'd1);
    mtx(1'b0, 32'hFFFF_FFFF);
    arith(4'd6, 32'd1, 32'd1, 0, 0);
    check("plan_maddu", {hi, lo}, 64'h0000_0002_0000_0000);
    arith(4'd7, 32'd1, 32'd1, 0, 0);
    check("plan_msub", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
    arith(4'd2, $urandom, $urandom, MUL_LAT - 1, 2);
    check("plan_cancel_keep", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
    arith(4'd3, $urandom, $urandom, 0, 1);
    reset_mid_div();

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        mtx(sel == 0, rand_operand());
      end else begin
        ro  = 4'($urandom_range(1, 8));
        lat = (ro == 4'd3 || ro == 4'd4) ? DIV_LAT : MUL_LAT;
        arith(ro, rand_operand(), rand_operand(),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0,
              $urandom_range(0, 2));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
